twiddle_cmul_pipe: RTL and testbench
====================================

TWIDDLE_CMUL_PIPE -- requirements
Module: twiddle_cmul_pipe

Interface
REQ-001 Parameters (name, default, meaning): DW, 16, signed data width of each real and imaginary component.
REQ-002 Parameters: FRAC, 8, number of twiddle fraction bits; C = round(0.7071067812 * 2^FRAC), giving 181 (0x00B5) at the default.
REQ-003 clk  in  1  the block's single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  input sample valid.
REQ-006 in_ready  out  1  the block accepts a sample on a cycle where in_valid=1 and in_ready=1.
REQ-007 a_re, a_im  in  DW each  signed input sample.
REQ-008 tw_idx  in  3  twiddle index k; W = e^(-j*2*pi*k/8).
REQ-009 inv  in  1  1 selects the conjugate twiddle W^(8-k) mod 8, for IFFT use.
REQ-010 out_valid  out  1  output sample valid.
REQ-011 out_ready  in  1  downstream accepts the output sample.
REQ-012 y_re, y_im  out  DW each  signed product a*W.
REQ-013 ovf  out  1  the sample on y_re/y_im was saturated; qualified by out_valid.

Function
REQ-014 Effective index: ke = inv ? (8-tw_idx) mod 8 : tw_idx.
REQ-015 Stage 1 registers operands P and Q (DW+1 bits) and the multiplier M according to ke:
- ke=0: P=ar, Q=ai, M=2^FRAC
- ke=1: P=ar+ai, Q=ai-ar, M=C
- ke=2: P=ai, Q=-ar, M=2^FRAC
- ke=3: P=ai-ar, Q=-(ar+ai), M=C
- ke=4: P=-ar, Q=-ai, M=2^FRAC
- ke=5: P=-(ar+ai), Q=ar-ai, M=C
- ke=6: P=-ai, Q=ar, M=2^FRAC
- ke=7: P=ar-ai, Q=ar+ai, M=C
REQ-016 Stage 2 registers full-precision products P*M and Q*M with no truncation.
REQ-017 Stage 3 rounds half-up (adds 2^(FRAC-1), then arithmetic right shift by FRAC), reduces to DW bits per REQ-027/028, and registers y_re, y_im and ovf.
REQ-018 Latency: exactly 3 clk cycles from acceptance to out_valid when the pipeline is not stalled; throughput is one sample per cycle.
REQ-019 Global advance enable en = !out_valid || out_ready; in_ready = en, driven combinationally.
REQ-020 When en=0, every pipeline register, including the valid bits, holds its value; y_re, y_im and ovf stay stable while out_valid=1 and out_ready=0.
REQ-021 When en=1, each stage valid bit loads the valid bit of the previous stage; the stage-1 valid bit loads in_valid && in_ready.
REQ-022 Bubbles are not collapsed; a stall freezes the whole pipeline.
REQ-023 tw_idx and inv are sampled only with the accepted data; a change at any other time has no effect.
REQ-024 The datapath registers are not required to hold any particular value while their valid bit is 0.

Reset
REQ-025 rst=1 at a clock edge clears all valid bits, out_valid, ovf, y_re and y_im to 0, and takes priority over en.
REQ-026 rst asserted mid-operation discards all in-flight samples; the first accepted sample after rst deasserts reaches out_valid 3 cycles later.

Configuration
REQ-027 With macro TWCMUL_SAT_EN defined, a result outside [-2^(DW-1), 2^(DW-1)-1] clamps to the nearest bound and sets ovf=1 for that sample; otherwise ovf=0.
REQ-028 With TWCMUL_SAT_EN undefined, results keep their low DW bits (two's-complement wrap) and ovf is tied to 0.

Verification
REQ-029 DW=16, FRAC=8, out_ready=1: a=(256,0), k=1, inv=0 -> y=(181,-181) exactly 3 cycles later, ovf=0.
REQ-030 a=(256,0), k=1, inv=1 -> y=(181,181); a=(256,0), k=2, inv=0 -> y=(0,-256).
REQ-031 a=(32767,32767), k=1 -> with SAT_EN y=(32767,0), ovf=1; without SAT_EN y=(-19201,0), ovf=0.
REQ-032 a=(-32768,0), k=4 -> with SAT_EN y=(32767,0), ovf=1.
REQ-033 Stream 8 samples with k=0..7 back-to-back and hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 results delivered in order with none lost or duplicated.
REQ-034 Assert rst for 1 cycle with 2 samples in flight -> out_valid=0 on the next cycle, neither in-flight sample emerges, and normal operation resumes afterwards.

Source files
------------

// File: rtl/twiddle_cmul_pipe_if.sv
// ============================================================================
//  Module      : twiddle_cmul_pipe_if
//  Description : Streaming handshake bundle for the radix-8 twiddle multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface twiddle_cmul_pipe_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] a_re;
    logic signed [DW-1:0] a_im;
    logic [2:0]           tw_idx;
    logic                 inv;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] y_re;
    logic signed [DW-1:0] y_im;
    logic                 ovf;

    modport master (
        output in_valid, a_re, a_im, tw_idx, inv, out_ready,
        input  in_ready, out_valid, y_re, y_im, ovf
    );

    modport slave (
        input  in_valid, a_re, a_im, tw_idx, inv, out_ready,
        output in_ready, out_valid, y_re, y_im, ovf
    );
endinterface

`default_nettype wire

// File: rtl/twiddle_cmul_pipe.sv
// ============================================================================
//  Module      : twiddle_cmul_pipe
//  Description : 3-stage complex multiply by an 8-point twiddle W^k (or its
//                conjugate); optional saturation enabled by macro TWCMUL_SAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module twiddle_cmul_pipe #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input wire clk,
    input wire rst,
    twiddle_cmul_pipe_if.slave bus
);

    localparam int c_pw  = DW + 1;          // stage-1 operand width
    localparam int c_mw  = FRAC + 2;        // signed multiplier width, holds 2^FRAC
    localparam int c_prw = c_pw + c_mw;     // full-precision product width
    localparam int c_rw  = c_prw + 1;       // product plus rounding headroom

    // 1/sqrt(2) in Q30, rounded down to FRAC bits with round-to-nearest
    localparam logic [63:0]             c_isqrt2_q30 = 64'd759250125;
    localparam logic [63:0]             c_tw_u = ((c_isqrt2_q30 << FRAC) + 64'd536870912) >> 30;
    localparam logic signed [c_mw-1:0]  c_tw   = c_mw'(c_tw_u);
    localparam logic signed [c_mw-1:0]  c_one  = c_mw'(64'd1 << FRAC);
    localparam logic signed [c_rw-1:0]  c_half = c_rw'(64'd1 << (FRAC - 1));

    logic w_en;

    logic                   r_v1, r_v2, r_v3;
    logic signed [c_pw-1:0] r_p, r_q;
    logic signed [c_mw-1:0] r_m;
    logic signed [c_prw-1:0] r_pr, r_qr;
    logic signed [DW-1:0]   r_yre, r_yim;
    logic                   r_ovf;

    assign w_en          = !r_v3 || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_v3;
    assign bus.y_re      = r_yre;
    assign bus.y_im      = r_yim;
    assign bus.ovf       = r_ovf;

    // ------------------------------------------------------------------
    // Stage 1 operand selection: rotations by multiples of 90 degrees are
    // swaps/negations, odd indices fold the 45-degree rotation into sums.
    // ------------------------------------------------------------------
    logic [2:0]             w_ke;
    logic signed [c_pw-1:0] w_ar, w_ai, w_sum, w_dif;
    logic signed [c_pw-1:0] w_p, w_q;
    logic signed [c_mw-1:0] w_m;

    assign w_ke  = bus.inv ? 3'(3'd0 - bus.tw_idx) : bus.tw_idx;
    assign w_ar  = {bus.a_re[DW-1], bus.a_re};
    assign w_ai  = {bus.a_im[DW-1], bus.a_im};
    assign w_sum = w_ar + w_ai;
    assign w_dif = w_ai - w_ar;

    always_comb begin
        w_p = w_ar;
        w_q = w_ai;
        w_m = c_one;
        case (w_ke)
            3'd0: begin w_p = w_ar;   w_q = w_ai;   w_m = c_one; end
            3'd1: begin w_p = w_sum;  w_q = w_dif;  w_m = c_tw;  end
            3'd2: begin w_p = w_ai;   w_q = -w_ar;  w_m = c_one; end
            3'd3: begin w_p = w_dif;  w_q = -w_sum; w_m = c_tw;  end
            3'd4: begin w_p = -w_ar;  w_q = -w_ai;  w_m = c_one; end
            3'd5: begin w_p = -w_sum; w_q = -w_dif; w_m = c_tw;  end
            3'd6: begin w_p = -w_ai;  w_q = w_ar;   w_m = c_one; end
            3'd7: begin w_p = -w_dif; w_q = w_sum;  w_m = c_tw;  end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 3 rounding and width reduction
    // ------------------------------------------------------------------
    function automatic logic signed [c_rw-1:0] rnd(input logic signed [c_prw-1:0] x);
        logic signed [c_rw-1:0] s;
        s = {x[c_prw-1], x} + c_half;
        return s >>> FRAC;
    endfunction

    logic signed [c_rw-1:0] w_rre, w_rim;
    logic signed [DW-1:0]   w_yre, w_yim;
    logic                   w_ovf;

    assign w_rre = rnd(r_pr);
    assign w_rim = rnd(r_qr);

`ifdef TWCMUL_SAT_EN
    localparam logic signed [c_rw-1:0] c_max = {{(c_rw-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_rw-1:0] c_min = {{(c_rw-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic signed [DW-1:0] sat(input logic signed [c_rw-1:0] r);
        if (r > c_max)
            return {1'b0, {(DW-1){1'b1}}};
        else if (r < c_min)
            return {1'b1, {(DW-1){1'b0}}};
        return r[DW-1:0];
    endfunction

    assign w_yre = sat(w_rre);
    assign w_yim = sat(w_rim);
    assign w_ovf = (w_rre > c_max) || (w_rre < c_min) ||
                   (w_rim > c_max) || (w_rim < c_min);
`else
    logic w_unused_hi;
    assign w_yre       = w_rre[DW-1:0];
    assign w_yim       = w_rim[DW-1:0];
    assign w_ovf       = 1'b0;
    assign w_unused_hi = ^{w_rre[c_rw-1:DW], w_rim[c_rw-1:DW]};
`endif

    // ------------------------------------------------------------------
    // Control: one enable freezes every stage, bubbles stay in place
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_yre <= '0;
            r_yim <= '0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_v1  <= bus.in_valid;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
            r_yre <= w_yre;
            r_yim <= w_yim;
            r_ovf <= w_ovf;
        end
    end

    // Datapath stages carry no reset; their contents are qualified by r_v*.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_p  <= w_p;
            r_q  <= w_q;
            r_m  <= w_m;
            r_pr <= r_p * r_m;
            r_qr <= r_q * r_m;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_twiddle_cmul_pipe.sv
// ============================================================================
//  Module      : tb_twiddle_cmul_pipe
//  Description : Self-checking bench: twiddle-table reference model, per-cycle
//                monitor with latency/stall tracking, directed and random phases.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_twiddle_cmul_pipe;

    localparam int  DW   = 16;
    localparam int  FRAC = 8;
    localparam real PI   = 3.14159265358979;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    twiddle_cmul_pipe_if #(.DW(DW)) bus ();

    twiddle_cmul_pipe #(.DW(DW), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int yr;
        int yi;
        bit ov;
        int acc;
        int st;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   stall_cnt = 0;
    int   n_out     = 0;
    int   last_yr, last_yi;
    bit   last_ov;
    bit   prev_rst  = 1'b0;
    bit   hold_valid = 1'b0;
    int   h_re, h_im;
    bit   h_ov;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: y = round_half_up(a * W * 2^FRAC) / 2^FRAC with W taken from
    // the unit circle, then reduced to DW bits.
    function automatic void reduce(input longint r, output int y, output bit o);
`ifdef TWCMUL_SAT_EN
        longint hi = (64'sd1 <<< (DW - 1)) - 1;
        longint lo = -(64'sd1 <<< (DW - 1));
        o = 1'b0;
        if (r > hi) begin y = int'(hi); o = 1'b1; end
        else if (r < lo) begin y = int'(lo); o = 1'b1; end
        else y = int'(r);
`else
        y = int'($signed(16'(r)));
        o = 1'b0;
`endif
    endfunction

    function automatic exp_t model(input int ar, input int ai, input int k, input bit iv);
        exp_t   e;
        int     ke;
        real    ang;
        longint wr, wi, pr, pim, rr, ri;
        bit     o1, o2;
        ke  = iv ? (8 - k) % 8 : k;
        ang = -2.0 * PI * real'(ke) / 8.0;
        wr  = longint'($rtoi($floor($cos(ang) * real'(1 << FRAC) + 0.5)));
        wi  = longint'($rtoi($floor($sin(ang) * real'(1 << FRAC) + 0.5)));
        pr  = longint'(ar) * wr - longint'(ai) * wi;
        pim = longint'(ar) * wi + longint'(ai) * wr;
        rr  = (pr  + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        ri  = (pim + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        reduce(rr, e.yr, o1);
        reduce(ri, e.yi, o2);
        e.ov  = o1 | o2;
        e.acc = 0;
        e.st  = 0;
        return e;
    endfunction

    // Single compare process, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (prev_rst) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_y_re", bus.y_re, 0);
            chk("rst_y_im", bus.y_im, 0);
            chk("rst_ovf", bus.ovf, 0);
        end
        if (rst) begin
            q.delete();
            hold_valid = 1'b0;
            prev_rst   = 1'b1;
        end else begin
            prev_rst = 1'b0;
            chk("in_ready_en", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (hold_valid) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_y_re", bus.y_re, h_re);
                chk("hold_y_im", bus.y_im, h_im);
                chk("hold_ovf", bus.ovf, h_ov);
            end
            hold_valid = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("y_re", bus.y_re, e.yr);
                    chk("y_im", bus.y_im, e.yi);
                    chk("ovf", bus.ovf, e.ov);
                    chk("latency", cyc - e.acc, 3 + stall_cnt - e.st);
                end
                n_out++;
                last_yr = bus.y_re;
                last_yi = bus.y_im;
                last_ov = bus.ovf;
            end else if (bus.out_valid) begin
                hold_valid = 1'b1;
                h_re = bus.y_re;
                h_im = bus.y_im;
                h_ov = bus.ovf;
                stall_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e = model(bus.a_re, bus.a_im, int'(bus.tw_idx), bus.inv);
                e.acc = cyc;
                e.st  = stall_cnt;
                q.push_back(e);
            end
        end
        cyc++;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int ar, input int ai, input int k, input bit iv);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.a_re     = 16'(ar);
        bus.a_im     = 16'(ai);
        bus.tw_idx   = 3'(k);
        bus.inv      = iv;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int target);
        for (int n = 0; n < 100 && n_out < target; n++) begin
            @(negedge clk);
            #1;
        end
        chk("output_arrived", n_out >= target, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input int ar, input int ai, input int k,
                            input bit iv, input int eyr, input int eyi, input bit eov);
        exp_t m;
        int   n0;
        m = model(ar, ai, k, iv);
        chk({name, "_model_re"}, m.yr, eyr);
        chk({name, "_model_im"}, m.yi, eyi);
        chk({name, "_model_ovf"}, m.ov, eov);
        n0 = n_out;
        send(ar, ai, k, iv);
        wait_outs(n0 + 1);
        chk({name, "_dut_re"}, last_yr, eyr);
        chk({name, "_dut_im"}, last_yi, eyi);
        chk({name, "_dut_ovf"}, last_ov, eov);
    endtask

    function automatic int rv();
        case ($urandom % 8)
            0: return -32768;
            1: return 32767;
            2: return -32767;
            default: return int'($signed(16'($urandom)));
        endcase
    endfunction

    initial begin
        int n0, s0;
        bus.in_valid  = 1'b0;
        bus.a_re      = '0;
        bus.a_im      = '0;
        bus.tw_idx    = '0;
        bus.inv       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        directed("k1",     256, 0, 1, 1'b0, 181, -181, 1'b0);
        directed("k1_inv", 256, 0, 1, 1'b1, 181,  181, 1'b0);
        directed("k2",     256, 0, 2, 1'b0,   0, -256, 1'b0);
        directed("k3",     100, -50, 3, 1'b0, -106, -35, 1'b0);
`ifdef TWCMUL_SAT_EN
        directed("big_k1", 32767, 32767, 1, 1'b0, 32767, 0, 1'b1);
        directed("neg_k4", -32768, 0, 4, 1'b0, 32767, 0, 1'b1);
`else
        directed("big_k1", 32767, 32767, 1, 1'b0, -19201, 0, 1'b0);
        directed("neg_k4", -32768, 0, 4, 1'b0, -32768, 0, 1'b0);
`endif

        // Back-to-back k=0..7 with a 5-cycle downstream stall mid-stream.
        n0 = n_out;
        s0 = stall_cnt;
        fork
            begin
                for (int k = 0; k < 8; k++)
                    send(1000 * (k + 1) - 4000, 300 - 700 * k, k, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_outs(n0 + 8);
        chk("stream_count", n_out - n0, 8);
        chk("stream_stall_cycles", stall_cnt - s0, 5);
        chk("stream_queue_empty", q.size(), 0);

        // Reset with two samples in flight.
        send(1234, -777, 5, 1'b0);
        send(-4321, 999, 6, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = n_out;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_flushed", n_out - n0, 0);
        directed("after_rst", 256, 0, 1, 1'b0, 181, -181, 1'b0);

        // Randomized traffic with random backpressure and idle index changes.
        for (int c = 0; c < 400; c++) begin
            int ar, ai;
            ar = rv();
            ai = rv();
            // -(ar+ai) is not representable in DW+1 bits when both are -2^(DW-1)
            if (ar == -32768 && ai == -32768) ai = -32767;
            bus.in_valid  = ($urandom % 4) != 0;
            bus.a_re      = 16'(ar);
            bus.a_im      = 16'(ai);
            bus.tw_idx    = 3'($urandom);
            bus.inv       = 1'($urandom);
            bus.out_ready = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 50 && q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("final_queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
